// File: rtl/prim_reqack_pkg.sv
// Shared types for the REQ/ACK responder.
package prim_reqack_pkg;

  typedef enum logic [0:0] {
    RESP_IDLE = 1'b0,
    RESP_PEND = 1'b1
  } reqack_resp_fsm_e;

endpackage

// File: rtl/prim_reqack_responder_if.sv
// Responder port bundle: request side plus local valid/ready output side.
interface prim_reqack_responder_if #(
  parameter int Width = 8,
  parameter int Depth = 4
);
  localparam int DepthW = $clog2(Depth + 1);

  logic              req_i;
  logic [Width-1:0]  req_data_i;
  logic              ack_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [Width-1:0]  out_data_o;
  logic [DepthW-1:0] depth_o;
  logic              proto_err_o;

  modport slave (
    input  req_i, req_data_i, out_ready_i,
    output ack_o, out_valid_o, out_data_o, depth_o, proto_err_o
  );

  modport master (
    output req_i, req_data_i, out_ready_i,
    input  ack_o, out_valid_o, out_data_o, depth_o, proto_err_o
  );
endinterface

// File: rtl/prim_reqack_buf.sv
// Circular payload buffer; pointers wrap at Depth-1 so Depth need not be a power of two.
module prim_reqack_buf #(
  parameter  int Width  = 8,
  parameter  int Depth  = 4,
  localparam int DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push,
  input  logic [Width-1:0]  push_data,
  input  logic              pop,
  output logic [Width-1:0]  pop_data,
  output logic              full,
  output logic              empty,
  output logic [DepthW-1:0] depth
);
  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (depth == DepthW'(Depth));
  assign empty    = (depth == '0);
  assign do_pop   = pop & ~empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_nxt(wr_ptr);
      if (do_pop) rd_ptr <= ptr_nxt(rd_ptr);
      case ({push, do_pop})
        2'b10:   depth <= depth + DepthW'(1);
        2'b01:   depth <= depth - DepthW'(1);
        default: depth <= depth;
      endcase
    end
  end

  // Storage needs no reset: reads are masked to 0 while empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> !full);

endmodule

// File: rtl/prim_reqack_responder.sv
// Destination-side REQ/ACK responder: latency gate, one-cycle ACK, buffered valid/ready output.
module prim_reqack_responder
  import prim_reqack_pkg::*;
#(
  parameter int Width  = 8,
  parameter int Depth  = 4,
  parameter int MinLat = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  prim_reqack_responder_if.slave bus
);
  localparam int CntW = (MinLat > 0) ? $clog2(MinLat + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MinLat);

  reqack_resp_fsm_e state;
  logic [CntW-1:0]  cnt, cnt_sat;
  logic             full, empty, accept, err;

  // Gated by reset so a request held through reset is never acknowledged.
  assign accept  = rst_ni & bus.req_i & ~full & (cnt == CntMax);
  assign cnt_sat = (cnt == CntMax) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= RESP_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        RESP_IDLE: begin
          if (bus.req_i && !accept) begin
            state <= RESP_PEND;
            cnt   <= cnt_sat;
          end
        end
        RESP_PEND: begin
          if (!bus.req_i) begin
            err   <= 1'b1;
            state <= RESP_IDLE;
            cnt   <= '0;
          end else if (accept) begin
            state <= RESP_IDLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt_sat;
          end
        end
      endcase
    end
  end

  prim_reqack_buf #(.Width(Width), .Depth(Depth)) u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (accept),
    .push_data (bus.req_data_i),
    .pop       (bus.out_ready_i),
    .pop_data  (bus.out_data_o),
    .full      (full),
    .empty     (empty),
    .depth     (bus.depth_o)
  );

  assign bus.ack_o       = accept;
  assign bus.out_valid_o = ~empty;
  assign bus.proto_err_o = err;

  a_ack_req: assert property (@(posedge clk_i) disable iff (!rst_ni) bus.ack_o |-> bus.req_i);

  // With MinLat=0 a back-to-back ACK belongs to a new request.
  if (MinLat > 0) begin : g_ack_once
    a_ack_once: assert property (@(posedge clk_i) disable iff (!rst_ni) bus.ack_o |=> !bus.ack_o);
  end

endmodule

// File: tb/tb_prim_reqack_responder.sv
// Two responders (MinLat 0 and 3) driven by random protocol-following initiators and checked against a queue model.
module tb_prim_reqack_responder;
  localparam int W = 8;
  localparam int D = 4;
  localparam int ML0 = 0;
  localparam int ML1 = 3;
  localparam int NCYC = 2000;

  typedef logic [W-1:0] data_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req [2];
  logic [W-1:0] dat [2];
  logic         rdy [2];
  logic         ack [2];
  logic         vld [2];
  logic [W-1:0] odat [2];
  logic [2:0]   dep [2];
  logic         perr [2];

  prim_reqack_responder_if #(.Width(W), .Depth(D)) bus0 ();
  prim_reqack_responder_if #(.Width(W), .Depth(D)) bus1 ();

  prim_reqack_responder #(.Width(W), .Depth(D), .MinLat(ML0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));
  prim_reqack_responder #(.Width(W), .Depth(D), .MinLat(ML1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));

  assign bus0.req_i = req[0];  assign bus0.req_data_i = dat[0];  assign bus0.out_ready_i = rdy[0];
  assign bus1.req_i = req[1];  assign bus1.req_data_i = dat[1];  assign bus1.out_ready_i = rdy[1];
  assign ack[0] = bus0.ack_o;  assign vld[0] = bus0.out_valid_o;  assign odat[0] = bus0.out_data_o;
  assign dep[0] = bus0.depth_o; assign perr[0] = bus0.proto_err_o;
  assign ack[1] = bus1.ack_o;  assign vld[1] = bus1.out_valid_o;  assign odat[1] = bus1.out_data_o;
  assign dep[1] = bus1.depth_o; assign perr[1] = bus1.proto_err_o;

  // Reference model: FIFO contents, cycles the current request has waited, sticky error.
  data_q_t q [2];
  int      seen [2];
  bit      pend [2];
  bit      merr [2];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_lat(input int i);
    return (i == 0) ? ML0 : ML1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      seen[i] = 0;
      pend[i] = 1'b0;
      merr[i] = 1'b0;
    end
  endtask

  // Compare pre-edge outputs, then advance the model as the next clock edge will.
  task automatic check_and_step();
    for (int i = 0; i < 2; i++) begin
      bit           eack;
      int           sz;
      logic [W-1:0] ehead;
      sz    = q[i].size();
      eack  = rst_n && req[i] && (sz < D) && (seen[i] >= min_lat(i));
      ehead = (sz > 0) ? q[i][0] : '0;
      chk($sformatf("ack%0d", i),   32'(ack[i]),  32'(eack));
      chk($sformatf("valid%0d", i), 32'(vld[i]),  32'(sz > 0));
      chk($sformatf("data%0d", i),  32'(odat[i]), 32'(ehead));
      chk($sformatf("depth%0d", i), 32'(dep[i]),  32'(sz));
      chk($sformatf("perr%0d", i),  32'(perr[i]), 32'(merr[i]));
      if (!rst_n) begin
        q[i].delete();
        seen[i] = 0;
        pend[i] = 1'b0;
        merr[i] = 1'b0;
      end else begin
        if (sz > 0 && rdy[i]) void'(q[i].pop_front());
        if (eack) begin
          q[i].push_back(dat[i]);
          pend[i] = 1'b0;
          seen[i] = 0;
        end else if (req[i]) begin
          pend[i] = 1'b1;
          seen[i]++;
        end else begin
          if (pend[i]) merr[i] = 1'b1;
          pend[i] = 1'b0;
          seen[i] = 0;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b1;
      dat[i] = 8'h5A;
      rdy[i] = 1'b0;
    end
    model_clear();
    rst_n = 1'b0;
    // Request held through reset must not be acknowledged or stored.
    repeat (3) begin
      @(negedge clk);
      check_and_step();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      int rdy_pct;
      case ((cyc / 150) % 3)
        0:       rdy_pct = 10;
        1:       rdy_pct = 50;
        default: rdy_pct = 90;
      endcase
      rst_n = (cyc % 400 == 399) ? 1'b0 : 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          req[i] = ($urandom_range(0, 63) != 0);
        end else begin
          req[i] = 1'($urandom_range(0, 1));
          dat[i] = 8'($urandom);
        end
        rdy[i] = ($urandom_range(0, 99) < rdy_pct);
      end
      @(negedge clk);
      check_and_step();
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
